// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared state encoding and default sizes for the instruction memory
package instr_mem_pkg;

   typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

   localparam int DEF_INSTR_W = 9;
   localparam int DEF_ADDR_W  = 12;

   localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/instr_ram.sv
// rtl/instr_ram.sv - simple dual-port RAM, one write port and one registered read port
module instr_ram
   import instr_mem_pkg::*;
#(
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [INSTR_W-1:0] rd_data
);

   logic [INSTR_W-1:0] mem [2**ADDR_W];

   // Contents are deliberately not reset; the controller's prog_len guards stale words.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - loadable instruction memory with bounds-checked one-cycle fetch
module instr_mem_ctrl
   import instr_mem_pkg::*;
#(
   parameter int                 INSTR_W  = DEF_INSTR_W,
   parameter int                 ADDR_W   = DEF_ADDR_W,
   parameter int                 PC_W     = 32,
   parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_INSTR)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_start,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               load_last,
   output logic               load_ready,
   output logic [ADDR_W:0]    prog_len,
   input  logic               fetch_req,
   input  logic [PC_W-1:0]    fetch_pc,
   output logic               fetch_ready,
   output logic               fetch_valid,
   output logic [INSTR_W-1:0] instruction,
   output logic               fetch_fault
);

   state_t             state;
   state_t             next_state;
   logic [ADDR_W-1:0]  wr_ptr;
   logic               load_acc;
   logic               fetch_acc;
   logic               fault;
   logic               sel_nop;
   logic [INSTR_W-1:0] ram_q;

   // Full-width compare so any PC bit above the index range forces a fault.
   assign fault = fetch_pc >= PC_W'(prog_len);

   always_comb begin
      next_state  = state;
      load_ready  = 1'b0;
      fetch_ready = 1'b0;
      load_acc    = 1'b0;
      fetch_acc   = 1'b0;
      case (state)
         EMPTY: begin
            if (load_start) next_state = LOADING;
         end
         LOADING: begin
            load_ready = 1'b1;
            load_acc   = load_valid && !load_start;
            if (load_acc && (load_last || wr_ptr == '1)) next_state = READY;
         end
         READY: begin
            fetch_ready = !load_start;
            fetch_acc   = fetch_req && !load_start;
            if (load_start) next_state = LOADING;
         end
         default: next_state = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= EMPTY;
         wr_ptr   <= '0;
         prog_len <= '0;
      end else begin
         state <= next_state;
         if (load_start) begin
            wr_ptr   <= '0;
            prog_len <= '0;
         end else if (load_acc) begin
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            prog_len <= prog_len + (ADDR_W+1)'(1);
         end
      end
   end

   // sel_nop and fetch_fault only move on an accepted fetch, so outputs hold between pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_valid <= 1'b0;
         fetch_fault <= 1'b0;
         sel_nop     <= 1'b1;
      end else begin
         fetch_valid <= fetch_acc;
         if (fetch_acc) begin
            fetch_fault <= fault;
            sel_nop     <= fault;
         end
      end
   end

   assign instruction = sel_nop ? NOP_WORD : ram_q;

   instr_ram #(
      .INSTR_W (INSTR_W),
      .ADDR_W  (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (load_acc),
      .wr_addr (wr_ptr),
      .wr_data (load_data),
      .rd_en   (fetch_acc && !fault),
      .rd_addr (fetch_pc[ADDR_W-1:0]),
      .rd_data (ram_q)
   );

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb/tb_instr_mem_ctrl.sv - scoreboard bench for instr_mem_ctrl
module tb_instr_mem_ctrl;
   import instr_mem_pkg::*;

   localparam int INSTR_W = 9;
   localparam int ADDR_W  = 12;
   localparam int PC_W    = 32;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam logic [INSTR_W-1:0] NOP = '0;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               load_start = 1'b0;
   logic               load_valid = 1'b0;
   logic [INSTR_W-1:0] load_data = '0;
   logic               load_last = 1'b0;
   logic               load_ready;
   logic [ADDR_W:0]    prog_len;
   logic               fetch_req = 1'b0;
   logic [PC_W-1:0]    fetch_pc = '0;
   logic               fetch_ready;
   logic               fetch_valid;
   logic [INSTR_W-1:0] instruction;
   logic               fetch_fault;

   always #5 clk = ~clk;

   instr_mem_ctrl #(
      .INSTR_W  (INSTR_W),
      .ADDR_W   (ADDR_W),
      .PC_W     (PC_W),
      .NOP_WORD (NOP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .prog_len    (prog_len),
      .fetch_req   (fetch_req),
      .fetch_pc    (fetch_pc),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .instruction (instruction),
      .fetch_fault (fetch_fault)
   );

   int                 n_checks = 0;
   int                 n_errors = 0;
   int                 exp_len = 0;
   logic [INSTR_W:0]   exp_q[$];
   logic [INSTR_W:0]   mon_e;
   logic [INSTR_W-1:0] mem_model [DEPTH];
   logic [INSTR_W-1:0] words[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Outputs sampled on the falling edge; main-flow checks run 1 time unit later.
   always @(negedge clk) begin
      if (fetch_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_fetch_valid", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("fetch_fault", 32'(fetch_fault), 32'(mon_e[INSTR_W]));
            check("instruction", 32'(instruction), 32'(mon_e[INSTR_W-1:0]));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic fetch(input logic [PC_W-1:0] pc);
      fetch_req = 1'b1;
      fetch_pc  = pc;
      if (longint'(pc) >= longint'(exp_len)) exp_q.push_back({1'b1, NOP});
      else exp_q.push_back({1'b0, mem_model[pc[ADDR_W-1:0]]});
      tick();
      fetch_req = 1'b0;
   endtask

   task automatic load(input logic [INSTR_W-1:0] w[$], input bit use_last, input bit do_start);
      if (do_start) begin
         load_start = 1'b1;
         tick();
         load_start = 1'b0;
      end
      exp_len = 0;
      for (int i = 0; i < w.size(); i++) begin
         load_valid   = 1'b1;
         load_data    = w[i];
         load_last    = use_last && (i == w.size() - 1);
         mem_model[i] = w[i];
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      exp_len    = w.size();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_load_ready"}, 32'(load_ready), 32'd0);
      check({tag, "_fetch_ready"}, 32'(fetch_ready), 32'd0);
      check({tag, "_fetch_valid"}, 32'(fetch_valid), 32'd0);
      check({tag, "_fetch_fault"}, 32'(fetch_fault), 32'd0);
      check({tag, "_instruction"}, 32'(instruction), 32'(NOP));
      check({tag, "_prog_len"}, 32'(prog_len), 32'd0);
      check({tag, "_state"}, 32'(dut.state), 32'(EMPTY));
   endtask

   initial begin
      repeat (2) tick();
      check_reset_outputs("reset");
      reset = 1'b0;
      tick();
      check("empty_state", 32'(dut.state), 32'(EMPTY));
      check("empty_fetch_ready", 32'(fetch_ready), 32'd0);

      // Basic 4-word program
      words = '{9'h101, 9'h0F2, 9'h003, 9'h1FF};
      load(words, 1'b1, 1'b1);
      check("len4", 32'(prog_len), 32'd4);
      check("len4_state", 32'(dut.state), 32'(READY));
      check("len4_load_ready", 32'(load_ready), 32'd0);
      check("len4_fetch_ready", 32'(fetch_ready), 32'd1);
      for (int pc = 0; pc < 4; pc++) begin
         fetch(PC_W'(pc));
         check("latency_one", 32'(exp_q.size()), 32'd0);
         tick();
         check("single_pulse", 32'(fetch_valid), 32'd0);
      end

      fetch(32'd3);
      fetch(32'd0);
      fetch(32'd2);
      check("back_to_back", 32'(exp_q.size()), 32'd0);
      fetch(32'd4);
      fetch(32'h0000_1000);
      tick();
      check("fault_drained", 32'(exp_q.size()), 32'd0);
      check("fault_hold", 32'(fetch_fault), 32'd1);

      // load_start beats a coincident fetch
      load_start = 1'b1;
      fetch_req  = 1'b1;
      fetch_pc   = '0;
      #1;
      check("refused_fetch_ready", 32'(fetch_ready), 32'd0);
      tick();
      load_start = 1'b0;
      fetch_req  = 1'b0;
      exp_len    = 0;
      check("restart_state", 32'(dut.state), 32'(LOADING));
      check("restart_len", 32'(prog_len), 32'd0);
      check("restart_load_ready", 32'(load_ready), 32'd1);
      words = '{9'h0AA};
      load(words, 1'b1, 1'b0);
      check("len1", 32'(prog_len), 32'd1);
      fetch(32'd1);
      fetch(32'd0);
      tick();
      check("len1_drained", 32'(exp_q.size()), 32'd0);

      // Fill the whole memory without load_last
      words.delete();
      for (int i = 0; i < DEPTH; i++) words.push_back(INSTR_W'($urandom));
      load(words, 1'b0, 1'b1);
      check("full_len", 32'(prog_len), 32'(DEPTH));
      check("full_state", 32'(dut.state), 32'(READY));
      check("full_load_ready", 32'(load_ready), 32'd0);
      fetch(PC_W'(DEPTH - 1));
      fetch(PC_W'(DEPTH));
      fetch(32'd0);
      fetch(32'd1234);
      tick();
      check("full_drained", 32'(exp_q.size()), 32'd0);

      // Reset mid-load
      words = '{9'h011, 9'h022, 9'h033, 9'h044};
      words = words[0:1];
      load(words, 1'b0, 1'b1);
      check("midload_len", 32'(prog_len), 32'd2);
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("midload");
      tick();
      reset   = 1'b0;
      exp_len = 0;
      tick();

      // Reset with a fetch in flight
      load(words, 1'b1, 1'b1);
      fetch_req = 1'b1;
      fetch_pc  = '0;
      @(posedge clk);
      #1;
      fetch_req = 1'b0;
      check("inflight_valid", 32'(fetch_valid), 32'd1);
      reset = 1'b1;
      #1;
      check_reset_outputs("midfetch");
      tick();
      reset   = 1'b0;
      exp_len = 0;
      tick();
      check("post_reset_fetch_ready", 32'(fetch_ready), 32'd0);
      check("final_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
